data_mem_arbiter: RTL and testbench
===================================

# data_mem_arbiter

Two-port round-robin arbiter that shares the single-port data memory between the CPU datapath (port 0) and a secondary master such as a DMA/loader/debug port (port 1). It sits directly in front of the data memory. It owns the memory's write enable, address and write-data inputs, and returns the memory's combinational read data to whichever port holds the grant. Grants are registered, are held while the owner keeps requesting, and are forcibly handed over after MAX_BURST cycles when the other port is waiting.

## Interface
- WIDTH, 8, data and address width (memory depth is 2^WIDTH).
- MAX_BURST, 4, maximum consecutive grant cycles for one port while the other port requests (legal range 1..255).

Ports:
- clk  in  1  system clock; all state updates on posedge.
- rst_n  in  1  asynchronous, active-low reset.
- req0, req1  in  1  access request from port 0 / port 1.
- we0, we1  in  1  write strobe, qualified by reqX and gntX.
- addr0, addr1  in  WIDTH  access address.
- wdata0, wdata1  in  WIDTH  write data.
- gnt0, gnt1  out  1  registered grant; at most one is high.
- rdata  out  WIDTH  read data, equal to mem_d_out; valid for the granted port only.
- mem_en  out  1  memory write enable.
- mem_addr  out  WIDTH  memory address.
- mem_d_in  out  WIDTH  memory write data.
- mem_d_out  in  WIDTH  memory combinational read data.

## Operation
- FSM states: IDLE, G0, G1. gnt0 = (state==G0) and gnt1 = (state==G1); both are decoded directly from registered state.
- Register `last` holds the most recently granted port. A burst counter `cnt` (8 bits) counts grant cycles of the current owner.
- Transitions, evaluated at posedge:
  - IDLE:
    - only req0 → G0.
    - only req1 → G1.
    - both requests → the port that is not `last`.
    - neither → IDLE.
  - Gx:
    - If !reqx: go to G(other) if the other port requests, else IDLE.
    - If reqx, the other port requests, and cnt == MAX_BURST-1: go to G(other).
    - Otherwise stay in Gx, with cnt saturating at MAX_BURST-1.
- On every entry into a Gx state: cnt ← 0 and last ← x.
- Datapath muxing is combinational and based on state:
  - G0: mem_addr = addr0, mem_d_in = wdata0, mem_en = req0 & we0.
  - G1: mem_addr = addr1, mem_d_in = wdata1, mem_en = req1 & we1.
  - IDLE: mem_addr = 0, mem_d_in = 0, mem_en = 0.
- rdata = mem_d_out at all times. A port must ignore rdata unless its gnt is high.
- A port may change addr/we/wdata every cycle while granted. Each granted cycle with reqx high is exactly one access.
- An unarbitrated write is impossible: mem_en is never high unless the matching gnt is high.

## Timing
- Reset (async assert on rst_n low):
  - state = IDLE; gnt0 = gnt1 = 0; cnt = 0; last = 1, so port 0 wins the first tie.
  - mem_en = 0, mem_addr = 0, mem_d_in = 0.
- Grant latency: a request sampled at posedge N produces gnt at posedge N (visible in cycle N+1). Minimum request-to-access latency is 1 cycle.
- Read: data appears on rdata in the same cycle gnt and addr are presented.
- Write: the memory captures the write at the posedge that ends a cycle with mem_en high.
- Handoff when contended: the owner gets exactly MAX_BURST grant cycles, then the other port gets the next cycle with no IDLE bubble. With MAX_BURST = 1 the grant alternates every cycle.
- Release: if the owner drops req in cycle k, gnt is still high in cycle k (no access, mem_en = 0). The new state takes effect in cycle k+1.
- Uncontended owner: the grant is held indefinitely.
- Requester lowering req while not granted: its request is withdrawn with no side effects.
- Reset mid-burst: gnt drops immediately (asynchronously), and any write in that cycle is aborted because mem_en is forced to 0.

## Test plan
- Reset: rst_n = 0 with req0 = req1 = 1, we0 = 1 → gnt0 = gnt1 = 0 and mem_en = 0 throughout. After release, the first grant is gnt0, one cycle later.
- Single writer: port 1 writes addr 0x10 = 0xA5, then reads 0x10 → gnt1 rises 1 cycle after req1, rdata = 0xA5 on the read cycle, and gnt0 stays 0.
- Contention, MAX_BURST = 4: req0 and req1 held continuously → grant pattern 0,0,0,0,1,1,1,1,0,… with no gap cycles and never both high.
- Early release: port 0 granted, drops req0 after 2 cycles while req1 is high → gnt1 in the cycle following the drop. The drop cycle has mem_en = 0.
- Tie after service: port 1 served and released, then both request in the same cycle from IDLE → port 0 is granted first.
- Async reset mid-write: rst_n is pulsed low mid-cycle during a port 0 write to 0x20 (old value 0x00, write data 0x3C) → mem_en falls immediately, and 0x20 still reads 0x00 afterward.

Source files
------------

// File: rtl/data_mem_arbiter.sv
// Round-robin arbiter sharing a single-port data memory between the CPU (port 0)
// and a secondary master (port 1), with a bounded burst length under contention.
module data_mem_arbiter #(
    parameter int WIDTH     = 8,
    parameter int MAX_BURST = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0,
    input  logic             req1,
    input  logic             we0,
    input  logic             we1,
    input  logic [WIDTH-1:0] addr0,
    input  logic [WIDTH-1:0] addr1,
    input  logic [WIDTH-1:0] wdata0,
    input  logic [WIDTH-1:0] wdata1,
    output logic             gnt0,
    output logic             gnt1,
    output logic [WIDTH-1:0] rdata,
    output logic             mem_en,
    output logic [WIDTH-1:0] mem_addr,
    output logic [WIDTH-1:0] mem_d_in,
    input  logic [WIDTH-1:0] mem_d_out
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] G0   = 2'd1;
    localparam logic [1:0] G1   = 2'd2;
    localparam logic [7:0] CNT_MAX = 8'(MAX_BURST - 1);

    logic [1:0] state, state_nxt;
    logic       last;
    logic [7:0] cnt;
    logic       hit_max;

    assign hit_max = (cnt == CNT_MAX);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (req0 && req1) state_nxt = last ? G0 : G1;
                else if (req0)    state_nxt = G0;
                else if (req1)    state_nxt = G1;
            end
            G0: begin
                if (!req0)                state_nxt = req1 ? G1 : IDLE;
                else if (req1 && hit_max) state_nxt = G1;
            end
            G1: begin
                if (!req1)                state_nxt = req0 ? G0 : IDLE;
                else if (req0 && hit_max) state_nxt = G0;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // last starts at 1 so port 0 wins the first tie after reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= 8'd0;
            last  <= 1'b1;
        end else begin
            state <= state_nxt;
            if (state_nxt != state && state_nxt != IDLE) begin
                cnt  <= 8'd0;
                last <= (state_nxt == G1);
            end else if (state != IDLE && !hit_max) begin
                cnt <= cnt + 8'd1;
            end
        end
    end

    assign gnt0  = (state == G0);
    assign gnt1  = (state == G1);
    assign rdata = mem_d_out;

    // Write enable is gated by the registered state, so reset kills it immediately
    always_comb begin
        mem_en   = 1'b0;
        mem_addr = '0;
        mem_d_in = '0;
        case (state)
            G0: begin
                mem_en   = req0 & we0;
                mem_addr = addr0;
                mem_d_in = wdata0;
            end
            G1: begin
                mem_en   = req1 & we1;
                mem_addr = addr1;
                mem_d_in = wdata1;
            end
            default: ;
        endcase
    end
endmodule

// File: tb/tb_data_mem_arbiter.sv
// Scoreboard bench for data_mem_arbiter: per-cycle grant expectations and read
// data are queued as stimulus is driven and retired on the falling clock edge.
module tb_data_mem_arbiter;
    localparam logic [1:0] N  = 2'b00;
    localparam logic [1:0] P0 = 2'b10;
    localparam logic [1:0] P1 = 2'b01;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       req0 = 1'b0, req1 = 1'b0, we0 = 1'b0, we1 = 1'b0;
    logic [7:0] addr0 = '0, addr1 = '0, wdata0 = '0, wdata1 = '0;
    logic       gnt0, gnt1, mem_en;
    logic [7:0] rdata, mem_addr, mem_d_in, mem_d_out;

    logic [7:0] mem [256];
    logic [1:0] gnt_q [$];
    logic [7:0] rd_q  [$];
    int checks = 0;
    int fails  = 0;

    data_mem_arbiter #(.WIDTH(8), .MAX_BURST(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .gnt0(gnt0), .gnt1(gnt1), .rdata(rdata),
        .mem_en(mem_en), .mem_addr(mem_addr), .mem_d_in(mem_d_in),
        .mem_d_out(mem_d_out)
    );

    always #5 clk = ~clk;

    // Memory model: combinational read, write on posedge
    assign mem_d_out = mem[mem_addr];
    always @(posedge clk) if (mem_en) mem[mem_addr] <= mem_d_in;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic cyc(input logic r0, input logic w0, input logic [7:0] a0, input logic [7:0] d0,
                       input logic r1, input logic w1, input logic [7:0] a1, input logic [7:0] d1,
                       input logic [1:0] eg);
        @(posedge clk); #1;
        req0 = r0; we0 = w0; addr0 = a0; wdata0 = d0;
        req1 = r1; we1 = w1; addr1 = a1; wdata1 = d1;
        gnt_q.push_back(eg);
    endtask

    always @(negedge clk) begin
        logic [7:0] ea, ed;
        ea = gnt0 ? addr0 : (gnt1 ? addr1 : 8'h00);
        ed = gnt0 ? wdata0 : (gnt1 ? wdata1 : 8'h00);
        if (gnt_q.size() > 0) chk("gnt", {gnt0, gnt1}, gnt_q.pop_front());
        chk("mem_en", mem_en, (gnt0 & req0 & we0) | (gnt1 & req1 & we1));
        chk("mem_addr", mem_addr, ea);
        chk("mem_d_in", mem_d_in, ed);
        if (rd_q.size() > 0 && ((gnt0 && req0 && !we0) || (gnt1 && req1 && !we1)))
            chk("rdata", rdata, rd_q.pop_front());
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0] eg;
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;

        // Reset held with both requesting and port 0 writing
        req0 = 1; req1 = 1; we0 = 1;
        for (int i = 0; i < 3; i++) cyc(1, 1, 8'h00, 8'h00, 1, 0, 8'h00, 8'h00, N);
        cyc(1, 1, 8'h00, 8'h00, 1, 0, 8'h00, 8'h00, N);
        rst_n = 1;
        cyc(1, 0, 8'h00, 8'h00, 1, 0, 8'h00, 8'h00, P0);
        cyc(0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00, P0);
        cyc(0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00, N);

        // Single writer on port 1, then read back
        cyc(0, 0, 8'h00, 8'h00, 1, 1, 8'h10, 8'hA5, N);
        cyc(0, 0, 8'h00, 8'h00, 1, 1, 8'h10, 8'hA5, P1);
        cyc(0, 0, 8'h00, 8'h00, 1, 0, 8'h10, 8'h00, P1);
        rd_q.push_back(8'hA5);
        cyc(0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00, P1);
        cyc(0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00, N);

        // Tie after port 1 service, then sustained contention (bursts of 4)
        for (int c = 0; c <= 15; c++) begin
            if (c == 0)       eg = N;
            else if (c == 15) eg = N;
            else              eg = (((c - 1) / 4) % 2 == 0) ? P0 : P1;
            cyc(c < 14, 0, 8'h01, 8'h00, c < 14, 0, 8'h02, 8'h00, eg);
        end

        // Uncontended hold past saturation, then req1 arrives and takes over next cycle
        cyc(1, 0, 8'h03, 8'h00, 0, 0, 8'h00, 8'h00, N);
        for (int c = 1; c <= 6; c++) cyc(1, 0, 8'h03, 8'h00, 0, 0, 8'h00, 8'h00, P0);
        cyc(1, 0, 8'h03, 8'h00, 1, 0, 8'h04, 8'h00, P0);
        cyc(0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00, P1);
        cyc(0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00, N);

        // Early release: port 0 writes twice, drops req0 while req1 waits
        cyc(1, 1, 8'h30, 8'h77, 1, 0, 8'h30, 8'h00, N);
        cyc(1, 1, 8'h30, 8'h77, 1, 0, 8'h30, 8'h00, P0);
        cyc(1, 1, 8'h30, 8'h77, 1, 0, 8'h30, 8'h00, P0);
        cyc(0, 1, 8'h30, 8'h77, 1, 0, 8'h30, 8'h00, P0);
        rd_q.push_back(8'h77);
        #1 chk("drop_mem_en", mem_en, 1'b0);
        cyc(0, 0, 8'h00, 8'h00, 1, 0, 8'h30, 8'h00, P1);
        cyc(0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00, P1);
        cyc(0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00, N);

        // Async reset in the middle of a port 0 write
        cyc(1, 1, 8'h20, 8'h3C, 0, 0, 8'h00, 8'h00, N);
        cyc(1, 1, 8'h20, 8'h3C, 0, 0, 8'h00, 8'h00, N);
        #1;
        chk("pre_rst_gnt0", gnt0, 1'b1);
        chk("pre_rst_en", mem_en, 1'b1);
        rst_n = 0;
        #1;
        chk("rst_gnt0", gnt0, 1'b0);
        chk("rst_en", mem_en, 1'b0);
        cyc(0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00, N);
        rst_n = 1;
        cyc(0, 0, 8'h00, 8'h00, 1, 0, 8'h20, 8'h00, N);
        rd_q.push_back(8'h00);
        cyc(0, 0, 8'h00, 8'h00, 1, 0, 8'h20, 8'h00, P1);
        cyc(0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00, P1);
        cyc(0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00, N);

        @(negedge clk); #1;
        chk("gnt_q_drained", gnt_q.size(), 0);
        chk("rd_q_drained", rd_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end
endmodule
